// File: rtl/load_read_ctrl.sv
// Load-stage read controller: issues word-aligned memory reads and returns extended load data.
// Optional macro LOAD_SPLIT_MISALIGNED_EN performs misaligned loads (two reads if crossing).
module load_read_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

`ifdef LOAD_SPLIT_MISALIGNED_EN
  typedef enum logic [1:0] {StIdle, StWait, StWait2, StResp} state_e;
  // Second read gets one extra cycle to present the incremented address.
  localparam logic [2:0] CntInit2 = 3'(READ_LATENCY);
`else
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
`endif
  localparam logic [2:0] CntInit = 3'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  fault_q, fault_d;
`ifdef LOAD_SPLIT_MISALIGNED_EN
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  cross_q, cross_d;
  logic                  req_crosses;
`else
  logic                  req_misaligned;
`endif
  logic                  req_illegal, req_half, req_word;

  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [63:0] sh;
    sh = pair >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh[31:0];
    endcase
  endfunction

  assign req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
  assign req_half    = (req_funct3[1:0] == 2'b01);
  assign req_word    = (req_funct3[1:0] == 2'b10);
`ifdef LOAD_SPLIT_MISALIGNED_EN
  assign req_crosses = (req_half && req_addr[1:0] == 2'b11) || (req_word && req_addr[1:0] != 2'b00);
`else
  assign req_misaligned = (req_half && req_addr[0]) || (req_word && req_addr[1:0] != 2'b00);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    f3_d      = f3_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    fault_d   = fault_q;
`ifdef LOAD_SPLIT_MISALIGNED_EN
    lo_d      = lo_q;
    cross_d   = cross_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          off_d   = req_addr[1:0];
          f3_d    = req_funct3;
          data_d  = '0;
          fault_d = 1'b0;
          if (req_illegal) begin
            fault_d = 1'b1;
            state_d = StResp;
`ifndef LOAD_SPLIT_MISALIGNED_EN
          end else if (req_misaligned) begin
            fault_d = 1'b1;
            state_d = StResp;
`endif
          end else begin
            rd_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            cnt_d     = CntInit;
            state_d   = StWait;
`ifdef LOAD_SPLIT_MISALIGNED_EN
            cross_d   = req_crosses;
`endif
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
`ifdef LOAD_SPLIT_MISALIGNED_EN
          if (cross_q) begin
            lo_d      = rd_data;
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(4);
            cnt_d     = CntInit2;
            state_d   = StWait2;
          end else begin
            data_d  = extract({32'b0, rd_data}, off_q, f3_q);
            state_d = StResp;
          end
`else
          data_d  = extract({32'b0, rd_data}, off_q, f3_q);
          state_d = StResp;
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
`ifdef LOAD_SPLIT_MISALIGNED_EN
      StWait2: begin
        if (cnt_q == 3'd0) begin
          data_d  = extract({rd_data, lo_q}, off_q, f3_q);
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
`endif
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      fault_q   <= 1'b0;
`ifdef LOAD_SPLIT_MISALIGNED_EN
      lo_q      <= '0;
      cross_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      fault_q   <= fault_d;
`ifdef LOAD_SPLIT_MISALIGNED_EN
      lo_q      <= lo_d;
      cross_q   <= cross_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_data  = data_q;
  assign resp_fault = fault_q;
  assign rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_load_read_ctrl.sv
// Directed bench for load_read_ctrl: one instance at READ_LATENCY=1, one at READ_LATENCY=3.
// Expectations follow LOAD_SPLIT_MISALIGNED_EN when it is defined for the build.
module tb_load_read_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_fault;
  logic [31:0] req_addr, resp_data, rd_addr, rd_data;
  logic [2:0]  req_funct3;

  logic        b_rst, b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_fault;
  logic [31:0] b_req_addr, b_resp_data, b_rd_addr, b_rd_data;
  logic [2:0]  b_req_funct3;

  logic [31:0] mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign rd_data   = mem[rd_addr[9:2]];
  assign b_rd_data = mem[b_rd_addr[9:2]];

  load_read_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  load_read_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_funct3(b_req_funct3), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_data(b_resp_data), .resp_fault(b_resp_fault),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the READ_LATENCY=1 instance; a1 is rd_addr right after the handshake,
  // a2 is rd_addr once the response is up; hold stretches the response with a stray request.
  task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] exp_data, input logic exp_fault, input int exp_lat,
                      input logic [31:0] a1, input logic [31:0] a2, input int hold);
    int n;
    @(negedge clk);
    check({tag, " req_ready idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = addr; req_funct3 = f3; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    check({tag, " rd_addr first"}, rd_addr, a1);
    while (resp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " data"}, resp_data, exp_data);
    check({tag, " fault"}, {31'b0, resp_fault}, {31'b0, exp_fault});
    check({tag, " rd_addr final"}, rd_addr, a2);
    check({tag, " req_ready busy"}, {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_addr = 32'h0000_0200; req_funct3 = 3'b000;
      @(negedge clk);
      check({tag, " hold valid"}, {31'b0, resp_valid}, 32'd1);
      check({tag, " hold data"}, resp_data, exp_data);
      check({tag, " hold fault"}, {31'b0, resp_fault}, {31'b0, exp_fault});
      check({tag, " hold req_ready"}, {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " resp drop"}, {31'b0, resp_valid}, 32'd0);
    check({tag, " req_ready back"}, {31'b0, req_ready}, 32'd1);
    check({tag, " rd_addr kept"}, rd_addr, a2);
  endtask

  task automatic load3(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
    int n;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = addr; b_req_funct3 = 3'b010; b_resp_ready = 1'b0;
    @(negedge clk);
    b_req_valid = 1'b0;
    n = 1;
    while (b_resp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    check({tag, " data"}, b_resp_data, exp_data);
    b_resp_ready = 1'b1;
    @(negedge clk);
    b_resp_ready = 1'b0;
    check({tag, " req_ready back"}, {31'b0, b_req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1; b_rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_funct3 = '0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_req_funct3 = '0; b_resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst rd_addr", rd_addr, 32'h0);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst resp_data", resp_data, 32'h0);
    check("rst resp_fault", {31'b0, resp_fault}, 32'd0);
    check("rst req_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b0; b_rst = 1'b0;

    mem[8'h40] = 32'hDEAD_BEEF;  // 0x100
    mem[8'h80] = 32'h80FF_7F01;  // 0x200
    mem[8'hC0] = 32'h8001_ABCD;  // 0x300
    load("lw", 32'h100, 3'b010, 32'hDEAD_BEEF, 1'b0, 2, 32'h100, 32'h100, 0);
    load("lb", 32'h203, 3'b000, 32'hFFFF_FF80, 1'b0, 2, 32'h200, 32'h200, 0);
    load("lbu", 32'h203, 3'b100, 32'h0000_0080, 1'b0, 2, 32'h200, 32'h200, 0);
    load("lh", 32'h302, 3'b001, 32'hFFFF_8001, 1'b0, 2, 32'h300, 32'h300, 0);
    load("lhu", 32'h302, 3'b101, 32'h0000_8001, 1'b0, 2, 32'h300, 32'h300, 0);
    load("illegal", 32'h400, 3'b011, 32'h0, 1'b1, 1, 32'h300, 32'h300, 0);
    load("backpressure", 32'h100, 3'b010, 32'hDEAD_BEEF, 1'b0, 2, 32'h100, 32'h100, 5);

`ifdef LOAD_SPLIT_MISALIGNED_EN
    mem[8'h40] = 32'h4433_2211;  // 0x100
    mem[8'h41] = 32'h8877_6655;  // 0x104
    load("lw split", 32'h101, 3'b010, 32'h5544_3322, 1'b0, 4, 32'h100, 32'h104, 0);
    load("lh inword", 32'h101, 3'b001, 32'h0000_3322, 1'b0, 2, 32'h100, 32'h100, 0);
    mem[8'hFF] = 32'hAABB_CCDD;  // 0xFFFFFFFC
    mem[8'h00] = 32'h1122_3344;  // 0x00000000
    load("lw wrap", 32'hFFFF_FFFE, 3'b010, 32'h3344_AABB, 1'b0, 4, 32'hFFFF_FFFC, 32'h0, 0);
    load("illegal split", 32'h101, 3'b111, 32'h0, 1'b1, 1, 32'h0, 32'h0, 0);
`else
    load("lw misaligned", 32'h101, 3'b010, 32'h0, 1'b1, 1, 32'h100, 32'h100, 0);
    load("lh misaligned", 32'h101, 3'b001, 32'h0, 1'b1, 1, 32'h100, 32'h100, 0);
    load("lw edge", 32'hFFFF_FFFE, 3'b010, 32'h0, 1'b1, 1, 32'h100, 32'h100, 0);
`endif

    load3("lat3 lw", 32'h200, 32'h80FF_7F01);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = 32'h300; b_req_funct3 = 3'b010;
    @(negedge clk);
    b_req_valid = 1'b0;
    check("lat3 rd_addr in wait", b_rd_addr, 32'h300);
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    check("abort resp_valid", {31'b0, b_resp_valid}, 32'd0);
    check("abort req_ready", {31'b0, b_req_ready}, 32'd1);
    check("abort rd_addr", b_rd_addr, 32'h0);
    check("abort resp_data", b_resp_data, 32'h0);
    check("abort resp_fault", {31'b0, b_resp_fault}, 32'd0);
    @(negedge clk);
    b_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_resp_valid !== 1'b0) seen++;
    end
    check("abort no response", 32'(seen), 32'd0);
    load3("lat3 after reset", 32'h300, 32'h8001_ABCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
